// File: rtl/pkt_head_slicer_pkg.sv
// Shared definitions for the packet head slicer: head tag bit positions,
// tag width, FSM state encoding and a tag builder.
package pkt_head_slicer_pkg;

  localparam int unsigned TAG_START_BIT = 0;
  localparam int unsigned TAG_VALID_BIT = 1;
  localparam int unsigned TAG_SHIFT_BIT = 2;
  localparam int unsigned TAG_TAIL_BIT  = 3;
  localparam int unsigned TAG_WIDTH     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    PAY  = 2'd2,
    DROP = 2'd3
  } state_e;

  // Tag for a valid head slice; the shift bit is never set.
  function automatic logic [TAG_WIDTH-1:0] make_tag(input logic start, input logic tail);
    logic [TAG_WIDTH-1:0] t;
    t                = '0;
    t[TAG_START_BIT] = start;
    t[TAG_VALID_BIT] = 1'b1;
    t[TAG_SHIFT_BIT] = 1'b0;
    t[TAG_TAIL_BIT]  = tail;
    return t;
  endfunction

endpackage

// File: rtl/pkt_head_slicer_if.sv
// Bus bundle of the packet head slicer.
//   input beat   : i_valid, i_sop, i_eop, i_data, i_cfg_headShift, o_ready
//   head path    : o_head (tag above data), o_headShift
//   payload path : o_pay_data, o_pay_valid, o_pay_eop, i_pay_ready
//   status       : o_err
// slave modport is the slicer side, master the driving/consuming side.
interface pkt_head_slicer_if #(
  parameter int unsigned HEAD_WIDTH       = 512,
  parameter int unsigned HEAD_SHIFT_WIDTH = 4
);
  import pkt_head_slicer_pkg::*;

  logic                            i_valid;
  logic                            i_sop;
  logic                            i_eop;
  logic [HEAD_WIDTH-1:0]           i_data;
  logic                            o_ready;
  logic [HEAD_SHIFT_WIDTH-1:0]     i_cfg_headShift;
  logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head;
  logic [HEAD_SHIFT_WIDTH-1:0]     o_headShift;
  logic [HEAD_WIDTH-1:0]           o_pay_data;
  logic                            o_pay_valid;
  logic                            o_pay_eop;
  logic                            i_pay_ready;
  logic                            o_err;

  modport slave (
    input  i_valid, i_sop, i_eop, i_data, i_cfg_headShift, i_pay_ready,
    output o_ready, o_head, o_headShift, o_pay_data, o_pay_valid, o_pay_eop, o_err
  );

  modport master (
    output i_valid, i_sop, i_eop, i_data, i_cfg_headShift, i_pay_ready,
    input  o_ready, o_head, o_headShift, o_pay_data, o_pay_valid, o_pay_eop, o_err
  );

endinterface

// File: rtl/pay_skid_buf.sv
// Two-entry payload skid buffer: an output register plus one skid register.
// Ports: clk, rst (async, active-high); push/push_data/push_eop write side;
// can_push = occupancy < 2; pay_data/pay_valid/pay_eop/pay_ready read side.
module pay_skid_buf #(
  parameter int unsigned DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_eop,
  output logic                  can_push,
  output logic [DATA_WIDTH-1:0] pay_data,
  output logic                  pay_valid,
  output logic                  pay_eop,
  input  logic                  pay_ready
);

  logic                  skid_valid, skid_valid_n;
  logic [DATA_WIDTH-1:0] skid_data, skid_data_n;
  logic                  skid_eop, skid_eop_n;
  logic                  out_valid_n, out_eop_n;
  logic [DATA_WIDTH-1:0] out_data_n;
  logic                  pop;

  // Skid entry is only occupied while the output entry is, so occupancy
  // reaches 2 exactly when the skid entry is full.
  always_comb begin
    pop          = pay_valid & pay_ready;
    out_valid_n  = pay_valid;
    out_data_n   = pay_data;
    out_eop_n    = pay_eop;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    skid_eop_n   = skid_eop;
    if (pop || !pay_valid) begin
      if (skid_valid) begin
        out_valid_n  = 1'b1;
        out_data_n   = skid_data;
        out_eop_n    = skid_eop;
        skid_valid_n = push;
        skid_data_n  = push_data;
        skid_eop_n   = push & push_eop;
      end else begin
        out_valid_n = push;
        out_data_n  = push_data;
        out_eop_n   = push & push_eop;
      end
    end else if (push) begin
      skid_valid_n = 1'b1;
      skid_data_n  = push_data;
      skid_eop_n   = push_eop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pay_valid  <= 1'b0;
      pay_data   <= '0;
      pay_eop    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_eop   <= 1'b0;
      can_push   <= 1'b1;
    end else begin
      pay_valid  <= out_valid_n;
      pay_data   <= out_data_n;
      pay_eop    <= out_eop_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      skid_eop   <= skid_eop_n;
      can_push   <= ~skid_valid_n;
    end
  end

endmodule

// File: rtl/pkt_head_slicer.sv
// Packet head slicer: the first HEAD_SLICE_NUM beats of each packet go out
// as tagged head slices (1-cycle registered, never stalled); remaining beats
// go through a 2-entry payload skid buffer.
// Ports: i_clk, i_rst (async, active-high), bus (pkt_head_slicer_if.slave).
// Optional macro HEAD_SLICER_STATS_EN adds o_pkt_cnt and o_err_cnt.
module pkt_head_slicer
  import pkt_head_slicer_pkg::*;
#(
  parameter int unsigned HEAD_WIDTH       = 512,
  parameter int unsigned HEAD_SLICE_NUM   = 4,
  parameter int unsigned HEAD_SHIFT_WIDTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  pkt_head_slicer_if.slave    bus
`ifdef HEAD_SLICER_STATS_EN
  ,
  output logic [31:0]         o_pkt_cnt,
  output logic [31:0]         o_err_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(HEAD_SLICE_NUM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HEAD_SLICE_NUM);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e                      state, state_nxt;
  logic [CNT_W-1:0]            cnt, cnt_nxt, cnt_inc;
  logic [HEAD_SHIFT_WIDTH-1:0] shift_q, shift_nxt;
  logic [TAG_WIDTH-1:0]        tag_q, tag_nxt;
  logic [HEAD_WIDTH-1:0]       hdata_q, hdata_nxt;
  logic                        err_q, err_nxt;
  logic                        push, push_eop;
  logic                        accept;

  assign accept          = bus.i_valid & bus.o_ready;
  assign bus.o_head      = {tag_q, hdata_q};
  assign bus.o_headShift = shift_q;
  assign bus.o_err       = err_q;

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shift_q <= '0;
      tag_q   <= '0;
      hdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shift_q <= shift_nxt;
      tag_q   <= tag_nxt;
      hdata_q <= hdata_nxt;
      err_q   <= err_nxt;
    end
  end

  // Next state, head slice, payload push and error pulse.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_nxt = shift_q;
    tag_nxt   = '0;
    hdata_nxt = '0;
    err_nxt   = 1'b0;
    push      = 1'b0;
    push_eop  = 1'b0;
    cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    if (accept) begin
      if (bus.i_sop) begin
        // A sop always starts a new packet; mid-packet it also flags an error.
        err_nxt   = (state == HEAD) || (state == PAY);
        shift_nxt = bus.i_cfg_headShift;
        cnt_nxt   = CNT_ONE;
        tag_nxt   = make_tag(1'b1, bus.i_eop || (CNT_MAX == CNT_ONE));
        hdata_nxt = bus.i_data;
        if (bus.i_eop)                state_nxt = IDLE;
        else if (CNT_MAX == CNT_ONE)  state_nxt = PAY;
        else                          state_nxt = HEAD;
      end else begin
        unique case (state)
          IDLE: begin
            err_nxt   = 1'b1;
            state_nxt = bus.i_eop ? IDLE : DROP;
          end
          HEAD: begin
            cnt_nxt   = cnt_inc;
            tag_nxt   = make_tag(1'b0, bus.i_eop || (cnt_inc == CNT_MAX));
            hdata_nxt = bus.i_data;
            if (bus.i_eop)                state_nxt = IDLE;
            else if (cnt_inc == CNT_MAX)  state_nxt = PAY;
          end
          PAY: begin
            push     = 1'b1;
            push_eop = bus.i_eop;
            if (bus.i_eop) state_nxt = IDLE;
          end
          DROP: begin
            if (bus.i_eop) state_nxt = IDLE;
          end
        endcase
      end
    end
  end

  pay_skid_buf #(
    .DATA_WIDTH (HEAD_WIDTH)
  ) u_pay_skid_buf (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .push_data (bus.i_data),
    .push_eop  (push_eop),
    .can_push  (bus.o_ready),
    .pay_data  (bus.o_pay_data),
    .pay_valid (bus.o_pay_valid),
    .pay_eop   (bus.o_pay_eop),
    .pay_ready (bus.i_pay_ready)
  );

`ifdef HEAD_SLICER_STATS_EN
  // Packet and error counters, wrapping modulo 2^32.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pkt_cnt <= '0;
      o_err_cnt <= '0;
    end else begin
      if (accept && bus.i_sop) o_pkt_cnt <= o_pkt_cnt + 32'd1;
      if (err_nxt)             o_err_cnt <= o_err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_head_slicer.sv
// Self-checking bench for pkt_head_slicer: expected head slices and payload
// beats are queued as stimulus is driven and popped by a negedge monitor.
module tb_pkt_head_slicer;
  import pkt_head_slicer_pkg::*;

  localparam int unsigned HW = 512;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 4;
  localparam int unsigned OW = HW + TAG_WIDTH;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pkt_head_slicer_if #(.HEAD_WIDTH(HW), .HEAD_SHIFT_WIDTH(SW)) bus ();

`ifdef HEAD_SLICER_STATS_EN
  logic [31:0] pkt_cnt;
  logic [31:0] err_cnt;
`endif

  pkt_head_slicer #(
    .HEAD_WIDTH       (HW),
    .HEAD_SLICE_NUM   (N),
    .HEAD_SHIFT_WIDTH (SW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef HEAD_SLICER_STATS_EN
    ,
    .o_pkt_cnt (pkt_cnt),
    .o_err_cnt (err_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;
  int err_seen = 0;
  int sop_sent = 0;
  logic [31:0] seq = 32'd0;

  logic [OW-1:0] head_q[$];
  logic [SW-1:0] hshift_q[$];
  logic [HW:0]   pay_q[$];

  logic [OW-1:0] mon_head;
  logic [SW-1:0] mon_shift;
  logic [HW:0]   mon_pay;

  function automatic logic [TAG_WIDTH-1:0] tg(input bit s, input bit t);
    logic [TAG_WIDTH-1:0] r;
    r = '0;
    r[TAG_START_BIT] = s;
    r[TAG_VALID_BIT] = 1'b1;
    r[TAG_TAIL_BIT]  = t;
    return r;
  endfunction

  function automatic logic [HW-1:0] mkdata();
    seq = seq + 32'd1;
    return HW'({$urandom, seq});
  endfunction

  task automatic exp_head(input logic [TAG_WIDTH-1:0] t, input logic [HW-1:0] d,
                          input logic [SW-1:0] s);
    head_q.push_back({t, d});
    hshift_q.push_back(s);
  endtask

  task automatic exp_pay(input bit eop, input logic [HW-1:0] d);
    pay_q.push_back({eop, d});
  endtask

  // Monitor: compares every head slice, idle tag and departing payload beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_head[HW+TAG_VALID_BIT] === 1'b1) begin
        total++;
        if (head_q.size() == 0) begin
          bad++;
          $display("FAIL head_unexpected tag=%h required=none", bus.o_head[HW+:TAG_WIDTH]);
        end else begin
          mon_head  = head_q.pop_front();
          mon_shift = hshift_q.pop_front();
          if (bus.o_head !== mon_head) begin
            bad++;
            $display("FAIL head_slice got=%h required=%h", bus.o_head, mon_head);
          end
          total++;
          if (bus.o_headShift !== mon_shift) begin
            bad++;
            $display("FAIL head_shift got=%0d required=%0d", bus.o_headShift, mon_shift);
          end
        end
      end else begin
        total++;
        if (bus.o_head[HW+:TAG_WIDTH] !== '0) begin
          bad++;
          $display("FAIL idle_tag got=%h required=0", bus.o_head[HW+:TAG_WIDTH]);
        end
      end
      if (bus.o_pay_valid === 1'b1 && bus.i_pay_ready === 1'b1) begin
        total++;
        if (pay_q.size() == 0) begin
          bad++;
          $display("FAIL pay_unexpected eop=%b required=none", bus.o_pay_eop);
        end else begin
          mon_pay = pay_q.pop_front();
          if ({bus.o_pay_eop, bus.o_pay_data} !== mon_pay) begin
            bad++;
            $display("FAIL pay_beat got=%h required=%h", {bus.o_pay_eop, bus.o_pay_data}, mon_pay);
          end
        end
      end
      if (bus.o_err === 1'b1) err_seen++;
    end
  end

  // Drive one beat from a negedge; returns at the negedge after acceptance.
  task automatic send(input bit sop, input bit eop, input logic [HW-1:0] d,
                      input logic [SW-1:0] cfg);
    int guard;
    guard = 0;
    bus.i_valid = 1'b1;
    bus.i_sop   = sop;
    bus.i_eop   = eop;
    bus.i_data  = d;
    bus.i_cfg_headShift = cfg;
    while (bus.o_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (guard >= 200) begin
      bad++;
      $display("FAIL send_timeout ready=%b required=1", bus.o_ready);
    end else begin
      if (sop) sop_sent++;
      @(posedge clk);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_sop   = 1'b0;
    bus.i_eop   = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((head_q.size() != 0 || pay_q.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (g >= 100) begin
      bad++;
      $display("FAIL drain_timeout heads=%0d pays=%0d required=0", head_q.size(), pay_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_err(input string name, input int base, input int req);
    total++;
    if (err_seen - base !== req) begin
      bad++;
      $display("FAIL %s err_pulses got=%0d required=%0d", name, err_seen - base, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    err_seen = 0;
    sop_sent = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.o_head !== '0)       begin bad++; $display("FAIL rst_head got=%h required=0", bus.o_head); end
    total++; if (bus.o_headShift !== '0)  begin bad++; $display("FAIL rst_shift got=%0d required=0", bus.o_headShift); end
    total++; if (bus.o_pay_valid !== 1'b0) begin bad++; $display("FAIL rst_pay_valid got=%b required=0", bus.o_pay_valid); end
    total++; if (bus.o_pay_eop !== 1'b0)  begin bad++; $display("FAIL rst_pay_eop got=%b required=0", bus.o_pay_eop); end
    total++; if (bus.o_err !== 1'b0)      begin bad++; $display("FAIL rst_err got=%b required=0", bus.o_err); end
    total++; if (bus.o_ready !== 1'b1)    begin bad++; $display("FAIL rst_ready got=%b required=1", bus.o_ready); end
`ifdef HEAD_SLICER_STATS_EN
    total++; if (pkt_cnt !== 32'd0 || err_cnt !== 32'd0) begin bad++; $display("FAIL rst_stats got=%0d/%0d required=0/0", pkt_cnt, err_cnt); end
`endif
    rst = 1'b0;
    err_seen = 0;
    sop_sent = 0;
    @(negedge clk);
    total++; if (bus.o_ready !== 1'b1)    begin bad++; $display("FAIL post_rst_ready got=%b required=1", bus.o_ready); end
  endtask

  task automatic test_err_idle();
    int base;
    base = err_seen;
    send(1'b0, 1'b0, mkdata(), 4'd1);
    send(1'b0, 1'b0, mkdata(), 4'd1);
    send(1'b0, 1'b1, mkdata(), 4'd1);
    wait_drain();
    check_err("err_idle_drop", base, 1);
    total++; if (bus.o_pay_valid !== 1'b0) begin bad++; $display("FAIL err_idle_payload got=%b required=0", bus.o_pay_valid); end
`ifdef HEAD_SLICER_STATS_EN
    total++; if (err_cnt !== 32'd1) begin bad++; $display("FAIL err_cnt got=%0d required=1", err_cnt); end
`endif
    base = err_seen;
    send(1'b0, 1'b1, mkdata(), 4'd1);
    wait_drain();
    check_err("err_idle_eop", base, 1);
  endtask

  task automatic test_short_pkt();
    logic [HW-1:0] d0, d1, d2;
    int base;
    base = err_seen;
    d0 = mkdata(); d1 = mkdata(); d2 = mkdata();
    exp_head(tg(1, 0), d0, 4'd5);
    exp_head(tg(0, 0), d1, 4'd5);
    exp_head(tg(0, 1), d2, 4'd5);
    send(1'b1, 1'b0, d0, 4'd5);
    send(1'b0, 1'b0, d1, 4'd9);
    send(1'b0, 1'b1, d2, 4'd9);
    wait_drain();
    check_err("short_pkt", base, 0);
    total++; if (bus.o_headShift !== 4'd5) begin bad++; $display("FAIL shift_hold got=%0d required=5", bus.o_headShift); end
    total++; if (bus.o_pay_valid !== 1'b0) begin bad++; $display("FAIL short_payload got=%b required=0", bus.o_pay_valid); end
  endtask

  task automatic test_long_pkt();
    logic [HW-1:0] d;
    int base;
    base = err_seen;
    for (int i = 0; i < 6; i++) begin
      d = mkdata();
      if (i < 4) exp_head(tg(i == 0, i == 3), d, 4'd9);
      else       exp_pay(i == 5, d);
      send(i == 0, i == 5, d, 4'd9);
    end
    wait_drain();
    check_err("long_pkt", base, 0);
  endtask

  task automatic test_single();
    logic [HW-1:0] d;
    int base;
    base = err_seen;
    d = mkdata(); exp_head(tg(1, 1), d, 4'd2); send(1'b1, 1'b1, d, 4'd2);
    d = mkdata(); exp_head(tg(1, 1), d, 4'd3); send(1'b1, 1'b1, d, 4'd3);
    wait_drain();
    check_err("single_beat", base, 0);
  endtask

  task automatic test_back_to_back();
    logic [HW-1:0] d;
    int base;
    base = err_seen;
    @(posedge clk); #1 bus.i_pay_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      d = mkdata();
      if (i < 4) exp_head(tg(i == 0, i == 3), d, 4'd12);
      else       exp_pay(1'b0, d);
      send(i == 0, 1'b0, d, 4'd12);
    end
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_drop got=%b required=0", bus.o_ready); end
    for (int i = 6; i < 10; i++) exp_pay(i == 9, HW'(0));
    // Payload data for beats 7..10 is fixed up below once generated.
    for (int i = 0; i < 4; i++) void'(pay_q.pop_back());
    fork
      begin
        for (int i = 6; i < 10; i++) begin
          d = mkdata();
          exp_pay(i == 9, d);
          send(1'b0, i == 9, d, 4'd0);
        end
      end
      begin
        repeat (5) @(negedge clk);
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_hold got=%b required=0", bus.o_ready); end
        @(posedge clk); #1 bus.i_pay_ready = 1'b1;
      end
    join
    wait_drain();
    check_err("back_to_back", base, 0);
  endtask

  task automatic test_sop_abort();
    logic [HW-1:0] d;
    int base;
    base = err_seen;
    d = mkdata(); exp_head(tg(1, 0), d, 4'd3); send(1'b1, 1'b0, d, 4'd3);
    d = mkdata(); exp_head(tg(1, 0), d, 4'd7); send(1'b1, 1'b0, d, 4'd7);
    d = mkdata(); exp_head(tg(0, 1), d, 4'd7); send(1'b0, 1'b1, d, 4'd3);
    wait_drain();
    check_err("sop_abort_head", base, 1);
    base = err_seen;
    for (int i = 0; i < 5; i++) begin
      d = mkdata();
      if (i < 4) exp_head(tg(i == 0, i == 3), d, 4'd1);
      else       exp_pay(1'b0, d);
      send(i == 0, 1'b0, d, 4'd1);
    end
    d = mkdata(); exp_head(tg(1, 1), d, 4'd2); send(1'b1, 1'b1, d, 4'd2);
    wait_drain();
    check_err("sop_abort_pay", base, 1);
  endtask

  task automatic test_reset_mid();
    logic [HW-1:0] d;
    int base;
    d = mkdata(); exp_head(tg(1, 0), d, 4'd4); send(1'b1, 1'b0, d, 4'd4);
    d = mkdata(); exp_head(tg(0, 0), d, 4'd4); send(1'b0, 1'b0, d, 4'd4);
    wait_drain();
    do_reset();
    total++; if (bus.o_headShift !== '0) begin bad++; $display("FAIL mid_rst_shift got=%0d required=0", bus.o_headShift); end
    base = err_seen;
    send(1'b0, 1'b1, mkdata(), 4'd8);
    wait_drain();
    check_err("post_rst_nosop", base, 1);
    base = err_seen;
    d = mkdata(); exp_head(tg(1, 1), d, 4'd6); send(1'b1, 1'b1, d, 4'd6);
    wait_drain();
    check_err("post_rst_pkt", base, 0);
`ifdef HEAD_SLICER_STATS_EN
    total++; if (pkt_cnt !== 32'(sop_sent)) begin bad++; $display("FAIL pkt_cnt got=%0d required=%0d", pkt_cnt, sop_sent); end
    total++; if (err_cnt !== 32'(err_seen)) begin bad++; $display("FAIL err_cnt_end got=%0d required=%0d", err_cnt, err_seen); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sop   = 1'b0;
    bus.i_eop   = 1'b0;
    bus.i_data  = '0;
    bus.i_cfg_headShift = '0;
    bus.i_pay_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_err_idle();
    test_short_pkt();
    test_long_pkt();
    test_single();
    test_back_to_back();
    test_sop_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pkt_head_slicer.md
PKT_HEAD_SLICER -- requirements
Module: pkt_head_slicer

Interface
REQ-001 SHALL take parameter HEAD_WIDTH, default 512, the beat and head-slice data width in bits.
REQ-002 SHALL take parameter HEAD_SLICE_NUM, default 4, the number of beats per packet routed to the head path.
REQ-003 SHALL take parameter HEAD_SHIFT_WIDTH, default 4, the width of the head shift value.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state changes on rising edge.
REQ-005 SHALL have port i_rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have ports i_valid, i_sop and i_eop, each input, 1: input beat qualifier, first beat and last beat.
REQ-007 SHALL have port i_data, input, HEAD_WIDTH, the packet beat.
REQ-008 SHALL have port o_ready, output, 1: the input beat is accepted when i_valid & o_ready.
REQ-009 SHALL have port i_cfg_headShift, input, HEAD_SHIFT_WIDTH, the shift for the packet, sampled on the sop beat.
REQ-010 SHALL have port o_head, output, HEAD_WIDTH+TAG_WIDTH, the tagged head slice: data in [0+:HEAD_WIDTH], tag above it.
REQ-011 SHALL have port o_headShift, output, HEAD_SHIFT_WIDTH, the shift value aligned with o_head.
REQ-012 SHALL have ports o_pay_data (output, HEAD_WIDTH), o_pay_valid (output, 1), o_pay_eop (output, 1) and i_pay_ready (input, 1): the payload stream.
REQ-013 SHALL have port o_err, output, 1, a one-cycle protocol-error pulse.

Function
REQ-014 SHALL implement FSM states IDLE, HEAD, PAY, DROP; reset state IDLE.
REQ-015 IDLE, accepted beat with sop: SHALL emit a head slice with START=1 and VALID=1, latch i_cfg_headShift, set slice count=1, then go to HEAD.
REQ-015a From IDLE, if that beat has eop: next state SHALL be IDLE instead of HEAD.
REQ-016 IDLE, accepted beat without sop: SHALL pulse o_err and go to DROP, or stay in IDLE if the beat has eop; no head or payload output.
REQ-017 HEAD: each accepted beat SHALL emit a slice with START=0 and VALID=1 and increment the count.
REQ-017a HEAD: when count reaches HEAD_SLICE_NUM SHALL go to PAY; on eop SHALL go to IDLE.
REQ-018 TAIL=1 SHALL be set on the slice carrying eop or the HEAD_SLICE_NUM-th slice, whichever comes first; a single-beat packet carries START=1 and TAIL=1.
REQ-019 PAY: accepted beats SHALL go to the payload skid buffer with eop preserved; eop SHALL return the FSM to IDLE.
REQ-020 DROP: SHALL discard beats until eop, then go to IDLE.
REQ-021 sop accepted in HEAD or PAY: SHALL pulse o_err and restart as a new packet per REQ-015.
REQ-021a The aborted packet SHALL get no TAIL slice and no payload eop.
REQ-022 Head path latency SHALL be exactly 1 cycle (registered).
REQ-022a On cycles with no accepted head beat, o_head VALID=0 and all other tag bits SHALL be 0.
REQ-022b TAG_SHIFT_BIT SHALL always be 0.
REQ-023 Payload SHALL use a 2-entry skid buffer, and o_ready SHALL equal (buffer occupancy < 2).
REQ-023a The head path SHALL never stall, since the downstream stage has no ready.
REQ-024 o_pay_valid SHALL be asserted when the buffer is non-empty; a beat leaves on o_pay_valid & i_pay_ready.
REQ-024a Simultaneous push and pop SHALL keep occupancy constant.
REQ-025 o_headShift SHALL hold the latched value until the next sop.
REQ-026 Slice count SHALL saturate at HEAD_SLICE_NUM and be cleared on sop.

Reset
REQ-027 While i_rst=1, all registers SHALL be cleared: o_head=0, o_headShift=0, o_pay_valid=0, o_pay_eop=0, o_err=0, buffer empty, FSM IDLE.
REQ-027a o_ready SHALL be 1 during reset and after release, since it is derived from an empty buffer.
REQ-028 Reset asserted mid-packet SHALL abandon the packet silently with no tail and no error.
REQ-028a After release, beats before the next sop SHALL follow REQ-016.

Configuration
REQ-029 Macro HEAD_SLICER_STATS_EN, when defined, SHALL add outputs o_pkt_cnt[31:0] (increments on accepted sop) and o_err_cnt[31:0] (increments on each o_err pulse).
REQ-029a Both counters SHALL wrap modulo 2^32 and be cleared by reset.
REQ-029b When the macro is undefined, these ports and counters SHALL be absent.

Structure
REQ-030 TAG_START_BIT, TAG_VALID_BIT, TAG_SHIFT_BIT, TAG_TAIL_BIT, TAG_WIDTH and the FSM state enum SHALL live in the shared parser package.
REQ-031 The skid buffer SHALL be a sub-module named pay_skid_buf.

Verification
REQ-032 3-beat packet, cfg=5, HEAD_SLICE_NUM=4 -> 3 slices tagged S/V, V, V+T; o_headShift=5; no payload; o_err=0.
REQ-033 6-beat packet -> 4 head slices with TAIL on the 4th, 2 payload beats with o_pay_eop on the last.
REQ-034 1-beat sop+eop packet -> a single slice with START=VALID=TAIL=1; FSM back to IDLE next cycle.
REQ-035 i_pay_ready=0 during a 10-beat packet -> o_ready drops after 2 buffered beats.
REQ-035a On raising i_pay_ready, all 6 payload beats SHALL arrive in order.
REQ-036 Beat without sop in IDLE, then 2 beats ending in eop -> o_err pulses once, nothing output, o_err_cnt=1 with the macro defined.
REQ-037 sop injected at beat 2 of a packet -> o_err pulse, new slice with START=1, and the old packet has no TAIL.
